// File: rtl/intc_timer_pkg.sv
// Shared register map, CTRL/STATUS bit positions and FSM states for intc_timer.
package intc_timer_pkg;

    localparam logic [1:0] ADDR_LOAD   = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int unsigned CTRL_EN_BIT   = 0;
    localparam int unsigned CTRL_AUTO_BIT = 1;
    localparam int unsigned STAT_EXP_BIT  = 0;
    localparam int unsigned STAT_ERR_BIT  = 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_EXPIRE = 2'd2
    } tmr_state_e;

endpackage

// File: rtl/intc_timer_prescaler.sv
// Tick generator for intc_timer: one tick every ps+1 cycles, restarted by clr.
// Only instantiated when TIMER_PRESCALE_EN is defined.
module tmr_prescaler #(
    parameter int unsigned PS_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic [PS_WIDTH-1:0] ps,
    output logic                tick
);

    logic [PS_WIDTH-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == ps);

    always_comb begin
        cnt_d = cnt_q + PS_WIDTH'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/intc_timer.sv
// Memory-mapped countdown timer producing a one-cycle done pulse for intc.
// Optional prescaler enabled by defining TIMER_PRESCALE_EN.
module intc_timer
    import intc_timer_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned PS_WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  A,
    input  logic        WE,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        done
);

    tmr_state_e       state_q, state_d;
    logic [WIDTH-1:0] load_q, load_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             en_q, en_d;
    logic             auto_q, auto_d;
    logic             exp_q, exp_d;
    logic             err_q, err_d;

    logic wr_load, wr_ctrl, wr_stat;
    logic exp_set, err_set;
    logic ps_clr, tick, go_reload;

    assign wr_load = WE && (A == ADDR_LOAD);
    assign wr_ctrl = WE && (A == ADDR_CTRL);
    assign wr_stat = WE && (A == ADDR_STATUS);

`ifdef TIMER_PRESCALE_EN
    logic [PS_WIDTH-1:0] ps_q, ps_d;

    assign ps_d = (WE && (A == ADDR_COUNT)) ? WD[PS_WIDTH-1:0] : ps_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end

    tmr_prescaler #(.PS_WIDTH(PS_WIDTH)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (ps_clr),
        .ps   (ps_q),
        .tick (tick)
    );
`else
    logic [PS_WIDTH:0] unused_cfg;

    assign unused_cfg = {{PS_WIDTH{1'b0}}, ps_clr};
    assign tick       = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        load_d    = wr_load ? WD[WIDTH-1:0] : load_q;
        en_d      = wr_ctrl ? WD[CTRL_EN_BIT] : en_q;
        auto_d    = wr_ctrl ? WD[CTRL_AUTO_BIT] : auto_q;
        count_d   = count_q;
        exp_set   = 1'b0;
        err_set   = 1'b0;
        ps_clr    = 1'b0;
        go_reload = en_d && auto_d;

        case (state_q)
            S_IDLE: begin
                if (wr_ctrl && WD[CTRL_EN_BIT]) begin
                    if (load_q != '0) begin
                        count_d = load_q;
                        ps_clr  = 1'b1;
                        state_d = S_RUN;
                    end else begin
                        en_d    = 1'b0;
                        err_set = 1'b1;
                    end
                end
            end
            S_RUN: begin
                // A stop request wins over a coinciding tick, so COUNT holds.
                if (!en_d) begin
                    state_d = S_IDLE;
                end else if (tick && (count_q != '0)) begin
                    count_d = count_q - WIDTH'(1);
                    if (count_q == WIDTH'(1)) begin
                        state_d = S_EXPIRE;
                    end
                end
            end
            S_EXPIRE: begin
                exp_set = 1'b1;
                if (go_reload && (load_q != '0)) begin
                    count_d = load_q;
                    ps_clr  = 1'b1;
                    state_d = S_RUN;
                end else begin
                    // A zero reload value would stall in RUN; flag it instead.
                    err_set = go_reload;
                    en_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        exp_d = exp_set | (exp_q & ~(wr_stat & WD[STAT_EXP_BIT]));
        err_d = err_set | (err_q & ~(wr_stat & WD[STAT_ERR_BIT]));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            load_q  <= '0;
            count_q <= '0;
            en_q    <= 1'b0;
            auto_q  <= 1'b0;
            exp_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
            count_q <= count_d;
            en_q    <= en_d;
            auto_q  <= auto_d;
            exp_q   <= exp_d;
            err_q   <= err_d;
        end
    end

    assign done = (state_q == S_EXPIRE);

    always_comb begin
        RD = '0;
        case (A)
            ADDR_LOAD:   RD[WIDTH-1:0] = load_q;
            ADDR_CTRL: begin
                RD[CTRL_EN_BIT]   = en_q;
                RD[CTRL_AUTO_BIT] = auto_q;
            end
            ADDR_COUNT:  RD[WIDTH-1:0] = count_q;
            ADDR_STATUS: begin
                RD[STAT_EXP_BIT] = exp_q;
                RD[STAT_ERR_BIT] = err_q;
            end
            default:     RD = '0;
        endcase
    end

endmodule
